// File: rtl/pong_sfx_gen_pkg.sv
// Shared types and constants for the Pong sound-effect generator: effect codes,
// sequencer states, note-table entries and default tone/decay parameters.
package pong_sfx_gen_pkg;

    localparam logic signed [31:0] AMP_DEFAULT         = 32'sd10000000;
    localparam int                 DECAY_SHIFT_DEFAULT = 9;
    localparam int                 GAP_SAMPLES_DEFAULT = 480;
    localparam int                 SAMPLE_RATE_HZ      = 48000;

    localparam int HP_W  = 19;
    localparam int DUR_W = 13;

    typedef enum logic [1:0] {
        SFX_NONE   = 2'd0,
        SFX_WALL   = 2'd1,
        SFX_PADDLE = 2'd2,
        SFX_SCORE  = 2'd3
    } sfx_id_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [HP_W-1:0]  half_period;
        logic [DUR_W-1:0] dur_samples;
        logic             last;
    } note_t;

    localparam note_t NOTE_WALL    = '{half_period: 19'd110619, dur_samples: 13'd2400, last: 1'b1};
    localparam note_t NOTE_PADDLE  = '{half_period: 19'd56818,  dur_samples: 13'd2400, last: 1'b1};
    localparam note_t NOTE_SCORE_0 = '{half_period: 19'd31888,  dur_samples: 13'd4800, last: 1'b0};
    localparam note_t NOTE_SCORE_1 = '{half_period: 19'd37936,  dur_samples: 13'd4800, last: 1'b0};
    localparam note_t NOTE_SCORE_2 = '{half_period: 19'd47801,  dur_samples: 13'd4800, last: 1'b1};
    // Non-zero fields keep the hp-1 / dur-1 compares well defined when nothing plays.
    localparam note_t NOTE_SILENT  = '{half_period: 19'd1,      dur_samples: 13'd1,    last: 1'b1};

endpackage

// File: rtl/pong_sfx_gen_sfx_note_rom.sv
// Combinational note table: maps the playing effect and note index to its
// half-period, duration and last-note flag.
module pong_sfx_gen_sfx_note_rom
    import pong_sfx_gen_pkg::*;
(
    input  sfx_id_e    sfx_id_i,
    input  logic [1:0] note_idx_i,
    output note_t      note_o
);

    always_comb begin
        note_o = NOTE_SILENT;
        case (sfx_id_i)
            SFX_WALL:   note_o = NOTE_WALL;
            SFX_PADDLE: note_o = NOTE_PADDLE;
            SFX_SCORE: begin
                case (note_idx_i)
                    2'd0:    note_o = NOTE_SCORE_0;
                    2'd1:    note_o = NOTE_SCORE_1;
                    default: note_o = NOTE_SCORE_2;
                endcase
            end
            default:    note_o = NOTE_SILENT;
        endcase
    end

endmodule

// File: rtl/pong_sfx_gen.sv
// Pong sound-effect source: arbitrates game events, sequences square-wave notes
// with stepped decay, and paces one sample write per free DAC FIFO slot.
module pong_sfx_gen
    import pong_sfx_gen_pkg::*;
#(
    parameter logic signed [31:0] AMP         = AMP_DEFAULT,
    parameter int                 DECAY_SHIFT = DECAY_SHIFT_DEFAULT,
    parameter int                 GAP_SAMPLES = GAP_SAMPLES_DEFAULT
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               evt_wall,
    input  logic               evt_paddle,
    input  logic               evt_score,
    input  logic               mute,
    input  logic               audio_out_allowed,
    output logic               write_audio_out,
    output logic signed [31:0] sample_out,
    output logic signed [31:0] left_channel_audio_out,
    output logic signed [31:0] right_channel_audio_out,
    output logic               busy,
    output logic [1:0]         sfx_id
);

    localparam int GAP_W = $clog2(GAP_SAMPLES);

    state_e             state_q, state_d;
    sfx_id_e            sfx_q, sfx_d;
    logic [1:0]         note_idx_q, note_idx_d;
    logic [DUR_W-1:0]   note_cnt_q, note_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [HP_W-1:0]    tone_cnt_q, tone_cnt_d;
    logic               pol_q, pol_d;
    logic               wr_q, wr_d;
    logic signed [31:0] sample_q, sample_d;

    note_t              note;
    sfx_id_e            evt_prio;
    logic               accept;
    logic [DUR_W-1:0]   att_raw;
    logic [2:0]         att;
    logic signed [31:0] amp_att;

    pong_sfx_gen_sfx_note_rom u_note_rom (
        .sfx_id_i   (sfx_q),
        .note_idx_i (note_idx_q),
        .note_o     (note)
    );

    always_comb begin
        evt_prio = SFX_NONE;
        if (evt_score)       evt_prio = SFX_SCORE;
        else if (evt_paddle) evt_prio = SFX_PADDLE;
        else if (evt_wall)   evt_prio = SFX_WALL;
    end

    // Equal priority re-triggers, so a repeated hit restarts its own effect.
    assign accept = (evt_prio != SFX_NONE) && (evt_prio >= sfx_q);

    assign att_raw = note_cnt_q >> DECAY_SHIFT;
    assign att     = (att_raw > DUR_W'(7)) ? 3'd7 : att_raw[2:0];
    assign amp_att = AMP >>> att;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sfx_q      <= SFX_NONE;
            note_idx_q <= '0;
            note_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tone_cnt_q <= '0;
            pol_q      <= 1'b1;
            wr_q       <= 1'b0;
            sample_q   <= '0;
        end else begin
            state_q    <= state_d;
            sfx_q      <= sfx_d;
            note_idx_q <= note_idx_d;
            note_cnt_q <= note_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            pol_q      <= pol_d;
            wr_q       <= wr_d;
            sample_q   <= sample_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sfx_d      = sfx_q;
        note_idx_d = note_idx_q;
        note_cnt_d = note_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tone_cnt_d = tone_cnt_q;
        pol_d      = pol_q;
        if (accept) begin
            state_d    = ST_PLAY;
            sfx_d      = evt_prio;
            note_idx_d = '0;
            note_cnt_d = '0;
            gap_cnt_d  = '0;
            tone_cnt_d = '0;
            pol_d      = 1'b1;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    // Tone phase runs on every clock; only note progress waits on writes.
                    if (tone_cnt_q >= note.half_period - 19'd1) begin
                        tone_cnt_d = '0;
                        pol_d      = ~pol_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 19'd1;
                    end
                    if (wr_d) begin
                        if (note_cnt_q == note.dur_samples - 13'd1) begin
                            note_cnt_d = '0;
                            if (note.last) begin
                                state_d = ST_IDLE;
                                sfx_d   = SFX_NONE;
                            end else begin
                                state_d   = ST_GAP;
                                gap_cnt_d = '0;
                            end
                        end else begin
                            note_cnt_d = note_cnt_q + 13'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (wr_d) begin
                        if (gap_cnt_q == GAP_W'(GAP_SAMPLES - 1)) begin
                            gap_cnt_d  = '0;
                            state_d    = ST_PLAY;
                            note_idx_d = note_idx_q + 2'd1;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GAP_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A write cycle is always followed by an idle one so the controller can refresh its FIFO status.
    always_comb begin
        wr_d     = audio_out_allowed && !wr_q;
        sample_d = '0;
        if (wr_d && (state_q == ST_PLAY) && !mute) begin
            sample_d = pol_q ? amp_att : -amp_att;
        end
    end

    assign write_audio_out         = wr_q;
    assign sample_out              = sample_q;
    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign busy                    = (state_q != ST_IDLE);
    assign sfx_id                  = sfx_q;

endmodule

// File: tb/tb_pong_sfx_gen.sv
// Scoreboard bench for pong_sfx_gen: a cycle model predicts every write strobe,
// a monitor compares each strobe, and directed steps check effect-level results.
module tb_pong_sfx_gen;

    localparam int AMP = 10000000;
    localparam int GAP = 480;

    logic               CLOCK_50 = 1'b0;
    logic               reset = 1'b1;
    logic               evt_wall = 1'b0;
    logic               evt_paddle = 1'b0;
    logic               evt_score = 1'b0;
    logic               mute = 1'b0;
    logic               audio_out_allowed = 1'b0;
    logic               write_audio_out;
    logic signed [31:0] sample_out;
    logic signed [31:0] left_channel_audio_out;
    logic signed [31:0] right_channel_audio_out;
    logic               busy;
    logic [1:0]         sfx_id;

    pong_sfx_gen dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .evt_wall                (evt_wall),
        .evt_paddle              (evt_paddle),
        .evt_score               (evt_score),
        .mute                    (mute),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .sample_out              (sample_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .busy                    (busy),
        .sfx_id                  (sfx_id)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int smp;
        bit bsy;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   seen[$];
    int   checks = 0;
    int   errors = 0;
    int   n_strobes = 0;
    int   busy_zero = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic note_lookup(input int id, input int idx, output int hp, output int dur, output bit last);
        hp = 1; dur = 1; last = 1'b1;
        case (id)
            1: begin hp = 110619; dur = 2400; last = 1'b1; end
            2: begin hp = 56818;  dur = 2400; last = 1'b1; end
            3: begin
                dur = 4800;
                if (idx == 0)      begin hp = 31888; last = 1'b0; end
                else if (idx == 1) begin hp = 37936; last = 1'b0; end
                else               begin hp = 47801; last = 1'b1; end
            end
            default: ;
        endcase
    endtask

    // Reference model: 0 idle, 1 play, 2 gap; predicts the strobe appearing after each edge.
    int m_state = 0, m_id = 0, m_note = 0, m_ns = 0, m_gap = 0, m_tone = 0;
    int m_hp, m_dur, m_att, m_prio, m_smp;
    bit m_pol = 1'b1, m_wr = 1'b0, m_wnow, m_last;
    exp_t m_e;

    initial begin : model
        forever begin
            @(posedge CLOCK_50);
            if (reset) begin
                m_state = 0; m_id = 0; m_note = 0; m_ns = 0; m_gap = 0;
                m_tone = 0; m_pol = 1'b1; m_wr = 1'b0;
            end else begin
                m_wnow = audio_out_allowed && !m_wr;
                note_lookup(m_id, m_note, m_hp, m_dur, m_last);
                m_smp = 0;
                if (m_state == 1 && !mute) begin
                    m_att = m_ns / 512;
                    if (m_att > 7) m_att = 7;
                    m_smp = AMP / (1 << m_att);
                    if (!m_pol) m_smp = -m_smp;
                end
                m_prio = evt_score ? 3 : (evt_paddle ? 2 : (evt_wall ? 1 : 0));
                if (m_prio != 0 && m_prio >= m_id) begin
                    m_state = 1; m_id = m_prio; m_note = 0; m_ns = 0; m_gap = 0;
                    m_tone = 0; m_pol = 1'b1;
                end else if (m_state == 1) begin
                    m_tone++;
                    if (m_tone == m_hp) begin m_tone = 0; m_pol = !m_pol; end
                    if (m_wnow) begin
                        m_ns++;
                        if (m_ns == m_dur) begin
                            m_ns = 0;
                            if (m_last) begin m_state = 0; m_id = 0; end
                            else begin m_state = 2; m_gap = 0; end
                        end
                    end
                end else if (m_state == 2 && m_wnow) begin
                    m_gap++;
                    if (m_gap == GAP) begin m_gap = 0; m_state = 1; m_note++; end
                end
                if (m_wnow) begin
                    m_e.smp = m_smp;
                    m_e.bsy = (m_state != 0);
                    m_e.id  = m_id;
                    exp_q.push_back(m_e);
                end
                m_wr = m_wnow;
            end
        end
    end

    exp_t mon_e;

    initial begin : monitor
        forever begin
            @(negedge CLOCK_50);
            if (write_audio_out) begin
                n_strobes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_sample", sample_out, mon_e.smp);
                    check("strobe_left", left_channel_audio_out, mon_e.smp);
                    check("strobe_right", right_channel_audio_out, mon_e.smp);
                    check("strobe_busy", busy, mon_e.bsy);
                    check("strobe_sfx_id", sfx_id, mon_e.id);
                end
                if (sample_out != 0) seen.push_back(sample_out);
                else if (busy) busy_zero++;
            end else if (exp_q.size() != 0) begin
                check("missing_strobe", 0, exp_q.size());
                exp_q.delete();
            end
        end
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic pulse(input logic [2:0] which);
        evt_wall   = which[0];
        evt_paddle = which[1];
        evt_score  = which[2];
        tick();
        evt_wall   = 1'b0;
        evt_paddle = 1'b0;
        evt_score  = 1'b0;
    endtask

    task automatic wait_seen(input string name, input int target, input int budget);
        int n = 0;
        while (seen.size() < target && n < budget) begin tick(); n++; end
        if (seen.size() < target) check(name, seen.size(), target);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        if (busy) check(name, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write"}, write_audio_out, 0);
        check({tag, "_sample"}, sample_out, 0);
        check({tag, "_left"}, left_channel_audio_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sfx_id"}, sfx_id, 0);
    endtask

    int b, bz, s0;

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Idle: writes every other cycle, all zero.
        audio_out_allowed = 1'b1;
        tick();
        s0 = n_strobes;
        repeat (20) tick();
        check("idle_strobe_count", n_strobes - s0, 10);
        check("idle_nonzero", seen.size(), 0);
        check("idle_busy", busy, 0);
        $display("idle: %0d strobes in 20 cycles", n_strobes - s0);

        // Paddle with a 10000-cycle backpressure stall mid-note.
        b = seen.size(); bz = busy_zero;
        pulse(3'b010);
        check("paddle_sfx_id", sfx_id, 2);
        check("paddle_busy", busy, 1);
        wait_seen("paddle_pre_stall_timeout", b + 1000, 5000);
        audio_out_allowed = 1'b0;
        s0 = n_strobes;
        repeat (10000) tick();
        check("stall_no_strobes", n_strobes - s0, 0);
        check("stall_frozen_count", seen.size() - b, 1000);
        audio_out_allowed = 1'b1;
        wait_idle("paddle_idle_timeout", 20000);
        check("paddle_tone_strobes", seen.size() - b, 2400);
        check("paddle_busy_zeros", busy_zero - bz, 0);
        check("paddle_first", seen[b], AMP);
        check("paddle_s511", seen[b + 511], AMP);
        check("paddle_s512", seen[b + 512], AMP / 2);
        check("paddle_last", seen[b + 2399], 625000);
        check("paddle_end_sfx_id", sfx_id, 0);
        $display("paddle: %0d tone strobes", seen.size() - b);

        // Score with a stall long enough for one polarity flip in note 0, plus a dropped wall hit.
        b = seen.size(); bz = busy_zero;
        pulse(3'b100);
        check("score_sfx_id", sfx_id, 3);
        wait_seen("score_pre_stall_timeout", b + 500, 3000);
        audio_out_allowed = 1'b0;
        repeat (31000) tick();
        audio_out_allowed = 1'b1;
        wait_seen("score_note1_timeout", b + 6000, 20000);
        pulse(3'b001);
        check("wall_in_score_sfx_id", sfx_id, 3);
        wait_idle("score_idle_timeout", 40000);
        check("score_tone_strobes", seen.size() - b, 14400);
        check("score_gap_zeros", busy_zero - bz, 2 * GAP);
        check("score_first", seen[b], AMP);
        check("score_s499", seen[b + 499], AMP);
        check("score_flipped", seen[b + 500], -AMP);
        check("score_note1_first", seen[b + 4800], -AMP);
        check("score_note2_first", seen[b + 9600], -AMP);
        check("score_last", seen[b + 14399], -78125);
        $display("score: %0d tone strobes, %0d gap zeros", seen.size() - b, busy_zero - bz);

        // Score interrupting wall restarts at note 0; then reset mid-note.
        b = seen.size();
        pulse(3'b001);
        check("wall_sfx_id", sfx_id, 1);
        wait_seen("wall_timeout", b + 600, 3000);
        check("wall_decay", seen[b + 599], AMP / 2);
        pulse(3'b100);
        check("restart_sfx_id", sfx_id, 3);
        wait_seen("restart_timeout", b + 700, 1000);
        check("restart_first", seen[b + 600], AMP);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (3) tick();
        check_all_zero("held_reset");
        reset = 1'b0;
        repeat (4) tick();
        check("post_reset_busy", busy, 0);
        s0 = n_strobes; b = seen.size();
        repeat (20) tick();
        check("post_reset_strobes", n_strobes - s0, 10);
        check("post_reset_nonzero", seen.size() - b, 0);
        $display("wall->score restart then reset: sfx_id %0d", sfx_id);

        // Simultaneous wall+paddle picks paddle; a later wall is dropped.
        pulse(3'b011);
        check("dual_sfx_id", sfx_id, 2);
        b = seen.size();
        wait_seen("dual_timeout", b + 100, 1000);
        pulse(3'b001);
        check("wall_dropped_sfx_id", sfx_id, 2);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        $display("wall+paddle: paddle selected");

        // Muted paddle: silent but same write count and busy span.
        mute = 1'b1;
        b = seen.size(); s0 = n_strobes;
        pulse(3'b010);
        check("mute_busy", busy, 1);
        s0 = n_strobes;
        wait_idle("mute_idle_timeout", 10000);
        check("mute_strobes", n_strobes - s0, 2400);
        check("mute_nonzero", seen.size() - b, 0);
        mute = 1'b0;
        $display("muted paddle: %0d strobes", n_strobes - s0);

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
